// File: rtl/nes_mem_pkg.sv
// Shared definitions for the NES memory blocks.
//   ram_state_t         : init-sequencer state (clearing / serving accesses)
//   NES_WRAM_ADDR_W     : physical address width of the 2 KiB system RAM
//   NES_WRAM_MIRROR_END : last CPU address of the mirrored work-RAM window
package nes_mem_pkg;

    typedef enum logic {
        RAM_CLEAR,
        RAM_READY
    } ram_state_t;

    localparam int          NES_WRAM_ADDR_W     = 11;
    localparam logic [15:0] NES_WRAM_MIRROR_END = 16'h1FFF;

endpackage

// File: rtl/nes_sys_ram_if.sv
// Bus bundle between the CPU decoder / OAM DMA engine and nes_sys_ram.
//   CPU side : addr, data_in, we -> data_out
//   DMA side : dma_addr, dma_re  -> dma_data, dma_valid
//   status   : ready (accesses honoured only while high)
// master = requester (CPU decoder + DMA engine), slave = the RAM.
interface nes_sys_ram_if #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 11,
    parameter int CPU_ADDR_W = 13
) ();

    logic [CPU_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data_in;
    logic                  we;
    logic [DATA_W-1:0]     data_out;
    logic [ADDR_W-1:0]     dma_addr;
    logic                  dma_re;
    logic [DATA_W-1:0]     dma_data;
    logic                  dma_valid;
    logic                  ready;

    modport master (
        output addr, data_in, we, dma_addr, dma_re,
        input  data_out, dma_data, dma_valid, ready
    );

    modport slave (
        input  addr, data_in, we, dma_addr, dma_re,
        output data_out, dma_data, dma_valid, ready
    );

endinterface

// File: rtl/nes_ram_core.sv
// Storage array: one synchronous write port, two synchronous read ports.
// Reads are read-first (a read at the edge of a write to the same word
// returns the old contents). The array itself has no reset.
//   clk                  : clock
//   wr_en/wr_addr/wr_data: write port
//   rd_a_en/rd_a_addr    : read port A request, rd_a_data registered result
//   rd_b_en/rd_b_addr    : read port B request, rd_b_data registered result
// A read data register only updates on an edge where its enable is high.
module nes_ram_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_a_en,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic              rd_b_en,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking reads sample the array before the same-edge write lands,
    // which gives the read-first behaviour on both ports.
    always_ff @(posedge clk) begin
        if (rd_a_en) begin
            rd_a_data <= mem[rd_a_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_b_en) begin
            rd_b_data <= mem[rd_b_addr];
        end
    end

endmodule

// File: rtl/nes_sys_ram.sv
// NES system work RAM with power-up clear sequencer and an OAM DMA read port.
//   clk : system clock
//   rst : asynchronous active-low reset (0 = in reset)
//   bus : nes_sys_ram_if slave modport
//         addr/data_in/we -> data_out   CPU port, 1-cycle registered read
//         dma_addr/dma_re -> dma_data/dma_valid  read-only DMA port
//         ready           high once the clear sequence has finished
// The CPU address is mirrored: only addr[ADDR_W-1:0] selects the word.
module nes_sys_ram
    import nes_mem_pkg::*;
#(
    parameter int                DATA_W         = 8,
    parameter int                ADDR_W         = NES_WRAM_ADDR_W,
    parameter int                CPU_ADDR_W     = $clog2(int'(NES_WRAM_MIRROR_END) + 1),
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL       = '0
) (
    input  logic          clk,
    input  logic          rst,
    nes_sys_ram_if.slave  bus
);

    localparam int               DEPTH     = 1 << ADDR_W;
    // One extra bit so the terminal compare never sees a wrapped value.
    localparam logic [ADDR_W:0]  CLR_LAST  = (ADDR_W+1)'(DEPTH - 1);
    localparam ram_state_t       RST_STATE = CLEAR_ON_RESET ? RAM_CLEAR : RAM_READY;

    ram_state_t        state_reg, state_next;
    logic [ADDR_W:0]   clr_cnt_reg, clr_cnt_next;
    logic              ready_reg;
    logic              cpu_seen_reg;
    logic              dma_seen_reg;
    logic              dma_valid_reg;

    logic              core_we;
    logic [ADDR_W-1:0] core_wa;
    logic [DATA_W-1:0] core_wd;
    logic              cpu_rd_en;
    logic              dma_rd_en;
    logic [DATA_W-1:0] cpu_q;
    logic [DATA_W-1:0] dma_q;

    // Mirroring: the upper CPU address bits are deliberately dropped.
    generate
        if (CPU_ADDR_W > ADDR_W) begin : g_mirror
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.addr[CPU_ADDR_W-1:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= RST_STATE;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Next state plus write-port / read-enable steering. Accesses wait for
    // ready_reg so nothing is honoured before ready is visible outside.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        core_we      = 1'b0;
        core_wa      = bus.addr[ADDR_W-1:0];
        core_wd      = bus.data_in;
        cpu_rd_en    = 1'b0;
        dma_rd_en    = 1'b0;
        case (state_reg)
            RAM_CLEAR: begin
                core_we      = 1'b1;
                core_wa      = clr_cnt_reg[ADDR_W-1:0];
                core_wd      = INIT_VAL;
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = RAM_READY;
                end
            end
            RAM_READY: begin
                if (ready_reg) begin
                    core_we   = bus.we;
                    cpu_rd_en = 1'b1;
                    dma_rd_en = bus.dma_re;
                end
            end
            default: begin
                state_next = RST_STATE;
            end
        endcase
    end

    // ready lags the state by one edge: with clearing enabled it rises one
    // cycle after the last word has been written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_reg     <= 1'b0;
            cpu_seen_reg  <= 1'b0;
            dma_seen_reg  <= 1'b0;
            dma_valid_reg <= 1'b0;
        end else begin
            ready_reg     <= (state_reg == RAM_READY);
            cpu_seen_reg  <= cpu_seen_reg | cpu_rd_en;
            dma_seen_reg  <= dma_seen_reg | dma_rd_en;
            dma_valid_reg <= dma_rd_en;
        end
    end

    nes_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk       (clk),
        .wr_en     (core_we),
        .wr_addr   (core_wa),
        .wr_data   (core_wd),
        .rd_a_en   (cpu_rd_en),
        .rd_a_addr (bus.addr[ADDR_W-1:0]),
        .rd_a_data (cpu_q),
        .rd_b_en   (dma_rd_en),
        .rd_b_addr (bus.dma_addr),
        .rd_b_data (dma_q)
    );

    // The array read registers carry no reset (keeps them in the RAM
    // primitive); the seen flags force the outputs to zero until the first
    // honoured read after reset, which also makes the zeroing asynchronous.
    assign bus.data_out  = cpu_seen_reg ? cpu_q : '0;
    assign bus.dma_data  = dma_seen_reg ? dma_q : '0;
    assign bus.dma_valid = dma_valid_reg;
    assign bus.ready     = ready_reg;

endmodule
